// File: rtl/if_inst_queue.sv
// ---------------------------------------------------------------------------
// if_inst_queue
//
// Instruction queue between the IF and ID stages. IF hands entries over with
// the same valid/allowin handshake ID would present; the queue buffers up to
// DEPTH of them and replays them to ID in program order. This decouples ID
// stalls from instruction SRAM requests.
//
// A flush (exception, ertn or branch redirect) empties the queue. Once an
// entry carrying a fetch exception (ADEF or any TLB exception bit) has been
// enqueued, further enqueues are held off until the next flush. Nothing
// fetched after a faulting instruction can be useful.
//
// Ports
//   clk          : clock, rising edge
//   resetn       : asynchronous active-low reset
//   fs2ds_valid  : IF presents a valid entry
//   fs2ds_bus    : IF entry {tlb_ex[7:0], inst[31:0], pc[31:0], adef}
//   ds_allowin   : queue accepts an entry this cycle (to IF)
//   flush        : discard all contents (wb_ex | ertn_flush | br_taken)
//   iq2ds_valid  : head entry valid toward ID
//   iq2ds_bus    : head entry payload
//   id_allowin   : ID takes the head entry this cycle
//   iq_count     : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_inst_queue #(
  parameter int DEPTH = 4,
  parameter int BUS_W = 73
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     fs2ds_valid,
  input  logic [BUS_W-1:0]         fs2ds_bus,
  output logic                     ds_allowin,
  input  logic                     flush,
  output logic                     iq2ds_valid,
  output logic [BUS_W-1:0]         iq2ds_bus,
  input  logic                     id_allowin,
  output logic [$clog2(DEPTH):0]   iq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             ex_hold;

  logic push;
  logic pop;
  logic in_is_ex;

  // The exception fields sit at the two ends of the bus: ADEF in bit 0 and the
  // 8-bit TLB exception vector in the top byte.
  assign in_is_ex = fs2ds_bus[0] | (|fs2ds_bus[BUS_W-1:BUS_W-8]);

  // ds_allowin looks only at registered state. A full queue therefore refuses
  // a push even in a cycle where ID pops. This keeps id_allowin off the
  // IF-side timing path.
  assign ds_allowin  = (count != CNT_FULL) & ~ex_hold;
  assign iq2ds_valid = (count != '0) & ~flush;

  assign push = fs2ds_valid & ds_allowin & ~flush;
  // iq2ds_valid already masks flush, so a pop can never happen in a flush cycle.
  assign pop  = iq2ds_valid & id_allowin;

  // The head is read straight from storage. There is no bypass from
  // fs2ds_bus, so an entry reaches ID one cycle after it is pushed at the
  // earliest.
  assign iq2ds_bus = mem[rptr];
  assign iq_count  = count;

  // NOTE: the payload array has no reset. Only the pointers, count and
  // ex_hold need one, because an entry is never observed until a push has
  // written it and advanced count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= fs2ds_bus;
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) only. Every
  // register then samples pre-edge values no matter how the statements are
  // ordered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ex_hold <= 1'b0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ex_hold <= 1'b0;
    end else begin
      // The pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push && in_is_ex) begin
        ex_hold <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_if_inst_queue
//
// Directed bench for if_inst_queue (DEPTH=4, BUS_W=73). Inputs are driven 1ns
// after the rising edge. Outputs are sampled 1ns after that, well clear of
// the next edge. Expected values are written out by hand in each step.
// ---------------------------------------------------------------------------
module tb_if_inst_queue;

  localparam int DEPTH = 4;
  localparam int BUS_W = 73;

  logic             clk;
  logic             resetn;
  logic             fs2ds_valid;
  logic [BUS_W-1:0] fs2ds_bus;
  logic             ds_allowin;
  logic             flush;
  logic             iq2ds_valid;
  logic [BUS_W-1:0] iq2ds_bus;
  logic             id_allowin;
  logic [2:0]       iq_count;

  int checks = 0;
  int errors = 0;

  if_inst_queue #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .fs2ds_valid (fs2ds_valid),
    .fs2ds_bus   (fs2ds_bus),
    .ds_allowin  (ds_allowin),
    .flush       (flush),
    .iq2ds_valid (iq2ds_valid),
    .iq2ds_bus   (iq2ds_bus),
    .id_allowin  (id_allowin),
    .iq_count    (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a bus entry. The instruction word is derived from the PC so that
  // the inst and PC fields carry different bit patterns.
  function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc, input logic adef,
                                          input logic [7:0] tlb);
    return {tlb, pc ^ 32'hffff_ffff, pc, adef};
  endfunction

  task automatic check(input string tag, input logic [BUS_W-1:0] obs,
                       input logic [BUS_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and move to the drive point 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle after the inputs change.
  task automatic settle();
    #1;
  endtask

  initial begin
    resetn      = 1'b0;
    fs2ds_valid = 1'b0;
    fs2ds_bus   = '0;
    flush       = 1'b0;
    id_allowin  = 1'b0;
    #22;

    // ---- reset state ----
    check("rst_valid",   BUS_W'(iq2ds_valid), BUS_W'(0));
    check("rst_allowin", BUS_W'(ds_allowin),  BUS_W'(1));
    check("rst_count",   BUS_W'(iq_count),    BUS_W'(0));
    resetn = 1'b1;
    tick();

    // ---- fill to DEPTH with id_allowin=0 ----
    for (int i = 0; i < 4; i++) begin
      fs2ds_valid = 1'b1;
      fs2ds_bus   = mk(32'h1C00_0000 + 32'(4 * i), 1'b0, 8'h00);
      tick();
    end
    check("full_count",   BUS_W'(iq_count),    BUS_W'(4));
    check("full_allowin", BUS_W'(ds_allowin),  BUS_W'(0));
    check("full_valid",   BUS_W'(iq2ds_valid), BUS_W'(1));

    // The 5th push is refused.
    fs2ds_bus = mk(32'h1C00_0010, 1'b0, 8'h00);
    settle();
    check("fifth_allowin", BUS_W'(ds_allowin), BUS_W'(0));
    tick();
    check("fifth_count", BUS_W'(iq_count), BUS_W'(4));
    check("fifth_head_pc", BUS_W'(iq2ds_bus[32:1]), BUS_W'(32'h1C00_0000));
    check("fifth_head_bus", iq2ds_bus, mk(32'h1C00_0000, 1'b0, 8'h00));

    // ---- full + pop + push attempt: the pop happens, the push is refused ----
    id_allowin = 1'b1;
    settle();
    check("fullpop_allowin", BUS_W'(ds_allowin), BUS_W'(0));
    tick();
    check("fullpop_count", BUS_W'(iq_count), BUS_W'(3));
    check("fullpop_head", BUS_W'(iq2ds_bus[32:1]), BUS_W'(32'h1C00_0004));
    // The next cycle the same offer is accepted. Hold ID off to see count rise.
    id_allowin = 1'b0;
    settle();
    check("reopen_allowin", BUS_W'(ds_allowin), BUS_W'(1));
    tick();
    check("reopen_count", BUS_W'(iq_count), BUS_W'(4));

    // Drain. The write pointer has wrapped, so the entry written last sits in slot 0.
    fs2ds_valid = 1'b0;
    id_allowin  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("drain%0d_valid", i), BUS_W'(iq2ds_valid), BUS_W'(1));
      check($sformatf("drain%0d_pc", i), BUS_W'(iq2ds_bus[32:1]),
            BUS_W'(32'h1C00_0004 + 32'(4 * i)));
      tick();
    end
    check("drained_count", BUS_W'(iq_count),    BUS_W'(0));
    check("drained_valid", BUS_W'(iq2ds_valid), BUS_W'(0));

    // ---- streaming: 12 PCs with id_allowin=1, one per cycle ----
    for (int c = 0; c < 14; c++) begin
      fs2ds_valid = (c < 12);
      fs2ds_bus   = mk(32'h1C00_0100 + 32'(4 * c), 1'b0, 8'h00);
      settle();
      if (c == 0 || c == 13) begin
        check($sformatf("stream%0d_valid", c), BUS_W'(iq2ds_valid), BUS_W'(0));
      end else begin
        check($sformatf("stream%0d_valid", c), BUS_W'(iq2ds_valid), BUS_W'(1));
        check($sformatf("stream%0d_pc", c), BUS_W'(iq2ds_bus[32:1]),
              BUS_W'(32'h1C00_0100 + 32'(4 * (c - 1))));
      end
      tick();
    end
    check("stream_end_count", BUS_W'(iq_count), BUS_W'(0));

    // ---- flush with a concurrent push ----
    id_allowin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fs2ds_valid = 1'b1;
      fs2ds_bus   = mk(32'h1C00_0200 + 32'(4 * i), 1'b0, 8'h00);
      tick();
    end
    check("preflush_count", BUS_W'(iq_count), BUS_W'(2));
    fs2ds_bus = mk(32'h1C00_0208, 1'b0, 8'h00);
    flush     = 1'b1;
    settle();
    check("flushcyc_valid", BUS_W'(iq2ds_valid), BUS_W'(0));
    tick();
    flush       = 1'b0;
    fs2ds_valid = 1'b0;
    id_allowin  = 1'b1;
    settle();
    check("postflush_count", BUS_W'(iq_count),    BUS_W'(0));
    check("postflush_valid", BUS_W'(iq2ds_valid), BUS_W'(0));
    tick();
    check("postflush_never", BUS_W'(iq2ds_valid), BUS_W'(0));

    // ---- ADEF exception hold ----
    id_allowin  = 1'b0;
    fs2ds_valid = 1'b1;
    fs2ds_bus   = mk(32'h1C00_0010, 1'b1, 8'h00);
    tick();
    fs2ds_bus = mk(32'h1C00_0014, 1'b0, 8'h00);
    settle();
    check("adef_allowin", BUS_W'(ds_allowin), BUS_W'(0));
    check("adef_count",   BUS_W'(iq_count),   BUS_W'(1));
    tick();
    check("adef_refused", BUS_W'(iq_count), BUS_W'(1));
    id_allowin = 1'b1;
    settle();
    check("adef_head_valid", BUS_W'(iq2ds_valid), BUS_W'(1));
    check("adef_head_bus", iq2ds_bus, mk(32'h1C00_0010, 1'b1, 8'h00));
    tick();
    check("adef_drained_count", BUS_W'(iq_count),    BUS_W'(0));
    check("adef_drained_valid", BUS_W'(iq2ds_valid), BUS_W'(0));
    check("adef_still_held",    BUS_W'(ds_allowin),  BUS_W'(0));
    fs2ds_valid = 1'b0;
    flush       = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    check("adef_flush_allowin", BUS_W'(ds_allowin), BUS_W'(1));

    // ---- TLB exception bit also sets the hold ----
    id_allowin  = 1'b0;
    fs2ds_valid = 1'b1;
    fs2ds_bus   = mk(32'h1C00_0020, 1'b0, 8'h40);
    tick();
    fs2ds_valid = 1'b0;
    settle();
    check("tlb_allowin", BUS_W'(ds_allowin), BUS_W'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    check("tlb_flush_allowin", BUS_W'(ds_allowin), BUS_W'(1));
    check("tlb_flush_count",   BUS_W'(iq_count),   BUS_W'(0));

    // ---- async reset mid-stream with 3 entries held ----
    for (int i = 0; i < 3; i++) begin
      fs2ds_valid = 1'b1;
      fs2ds_bus   = mk(32'h1C00_0300 + 32'(4 * i), 1'b0, 8'h00);
      tick();
    end
    fs2ds_valid = 1'b0;
    settle();
    check("prereset_count", BUS_W'(iq_count), BUS_W'(3));
    resetn = 1'b0;
    settle();
    check("areset_valid",   BUS_W'(iq2ds_valid), BUS_W'(0));
    check("areset_count",   BUS_W'(iq_count),    BUS_W'(0));
    check("areset_allowin", BUS_W'(ds_allowin),  BUS_W'(1));
    tick();
    resetn = 1'b1;
    tick();

    // Normal operation resumes after reset.
    fs2ds_valid = 1'b1;
    fs2ds_bus   = mk(32'h1C00_0400, 1'b0, 8'h00);
    tick();
    fs2ds_valid = 1'b0;
    settle();
    check("after_reset_valid", BUS_W'(iq2ds_valid), BUS_W'(1));
    check("after_reset_pc", BUS_W'(iq2ds_bus[32:1]), BUS_W'(32'h1C00_0400));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
